// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that locks one of two byte streams onto a UART transmitter per message
module uart_tx_arbiter #(
  parameter int ACK_HOLD = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_a_valid,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_last,
  output logic              o_a_ready,
  output logic              o_a_done,
  input  logic              i_b_valid,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_last,
  output logic              o_b_ready,
  output logic              o_b_done,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic [1:0]        o_grant
);
  localparam int CW = ACK_HOLD > 1 ? $clog2(ACK_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(ACK_HOLD - 1);
  typedef enum logic [1:0] {IDLE, FETCH, START, WAIT_DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_grant, r_done, w_pick;
  logic r_last_b, r_last, w_fire, w_finish, w_hold_done, w_sel_last;
  logic [DATA_W-1:0] r_data, w_sel_data;
  logic [CW-1:0] r_cnt;
  // A wins a tie unless A was served last
  assign w_pick = (i_a_valid && (!i_b_valid || r_last_b)) ? 2'b01 : 2'b10;
  assign w_sel_data = r_grant[1] ? i_b_data : i_a_data;
  assign w_sel_last = r_grant[1] ? i_b_last : i_a_last;
  assign w_fire = r_state == FETCH && (r_grant[1] ? i_b_valid : i_a_valid);
  assign w_hold_done = r_cnt == HOLD_MAX;
  assign w_finish = r_state == WAIT_DONE && !i_tx_busy && r_last;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (i_a_valid || i_b_valid) ? FETCH : IDLE;
      FETCH:     w_next = w_fire ? START : FETCH;
      START:     w_next = (w_hold_done && i_tx_busy) ? WAIT_DONE : START;
      WAIT_DONE: w_next = i_tx_busy ? WAIT_DONE : (r_last ? IDLE : FETCH);
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 2'b00;
      r_done <= 2'b00;
      r_last_b <= 1'b1;
      r_last <= 1'b0;
      r_data <= '0;
      r_cnt <= '0;
    end else begin
      // done is registered so it coincides with grant returning to 00
      r_done <= w_finish ? r_grant : 2'b00;
      if (r_state == IDLE && w_next == FETCH) r_grant <= w_pick;
      else if (w_finish) begin
        r_grant <= 2'b00;
        r_last_b <= r_grant[1];
      end
      if (w_fire) begin
        r_data <= w_sel_data;
        r_last <= w_sel_last;
        r_cnt <= '0;
      end else if (r_state == START && !w_hold_done) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_grant = r_grant;
  assign o_a_ready = r_state == FETCH && r_grant[0];
  assign o_b_ready = r_state == FETCH && r_grant[1];
  assign o_a_done = r_done[0];
  assign o_b_done = r_done[1];
  assign o_tx_start = r_state == START;
  assign o_tx_data = r_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks against a message-level arbitration model
module tb_uart_tx_arbiter;
  localparam int AH = 16;
  logic clk = 0, rst_n = 0;
  logic a_valid = 0, a_last = 0, b_valid = 0, b_last = 0, tx_busy = 0;
  logic [7:0] a_data = 0, b_data = 0;
  logic a_ready, a_done, b_ready, b_done, tx_start;
  logic [7:0] tx_data;
  logic [1:0] grant;
  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_tx[$];
  logic exp_done[$];
  logic model_last_b = 1;
  logic [7:0] ma[$], mb[$];
  int bdelay = 3, blen = 20, scnt = 0, bc = 0, st_len = 0;
  logic [7:0] ep_data;
  logic ep_stable, who;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.ACK_HOLD(AH), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_a_valid(a_valid), .i_a_data(a_data), .i_a_last(a_last), .o_a_ready(a_ready), .o_a_done(a_done),
    .i_b_valid(b_valid), .i_b_data(b_data), .i_b_last(b_last), .o_b_ready(b_ready), .o_b_done(b_done),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy), .o_grant(grant)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // transmitter: busy rises bdelay cycles after tx_start, falls blen cycles later once tx_start is gone
  always @(negedge clk) begin
    if (!tx_busy) begin
      scnt = tx_start ? scnt + 1 : 0;
      if (tx_start && scnt == bdelay + 1) begin
        tx_busy = 1;
        bc = 0;
      end
    end else begin
      bc++;
      if (bc >= blen && !tx_start) begin
        tx_busy = 0;
        scnt = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) st_len = 0;
    else begin
      if (a_ready) chk("a_rdy_own", grant, 2'b01);
      if (b_ready) chk("b_rdy_own", grant, 2'b10);
      if (tx_start && st_len == 0) begin
        if (exp_tx.size() == 0) chk("tx_spurious", 1, 0);
        else chk("tx_data", tx_data, exp_tx.pop_front());
        ep_data = tx_data;
        ep_stable = 1;
        st_len = 1;
      end else if (tx_start) begin
        st_len++;
        if (tx_data !== ep_data) ep_stable = 0;
      end else if (st_len > 0) begin
        chk("tx_len", st_len, (bdelay + 1 > AH) ? bdelay + 1 : AH);
        chk("tx_stable", ep_stable, 1);
        st_len = 0;
      end
      if (a_done || b_done) begin
        chk("done_grant", grant, 0);
        if (exp_done.size() == 0) chk("done_spurious", 1, 0);
        else begin
          who = exp_done.pop_front();
          chk("done_who", {b_done, a_done}, who ? 2'b10 : 2'b01);
        end
      end
    end
  end
  task automatic set_req(bit side, logic v, logic [7:0] d, logic l);
    if (side) begin
      b_valid = v; b_data = d; b_last = l;
    end else begin
      a_valid = v; a_data = d; a_last = l;
    end
  endtask
  task automatic wait_rdy(bit side, output bit ok);
    int t = 0;
    while (!(side ? b_ready : a_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = t < 3000;
    if (!ok) chk(side ? "b_rdy_timeout" : "a_rdy_timeout", 0, 1);
  endtask
  task automatic send(bit side, int g);
    logic [7:0] q[$];
    bit ok;
    if (side) q = mb;
    else q = ma;
    foreach (q[i]) begin
      if (i > 0 && g > 0) begin
        set_req(side, 0, 0, 0);
        wait_rdy(side, ok);
        if (!ok) return;
        repeat (g) begin
          chk("stall_rdy", side ? b_ready : a_ready, 1);
          chk("stall_nostart", tx_start, 0);
          @(negedge clk);
        end
      end
      set_req(side, 1, q[i], i == q.size() - 1);
      wait_rdy(side, ok);
      if (!ok) begin
        set_req(side, 0, 0, 0);
        return;
      end
      @(negedge clk);
    end
    set_req(side, 0, 0, 0);
  endtask
  task automatic push_msg(bit side);
    if (side) foreach (mb[i]) exp_tx.push_back(mb[i]);
    else foreach (ma[i]) exp_tx.push_back(ma[i]);
    exp_done.push_back(side);
  endtask
  task automatic wait_end();
    int t = 0;
    while ((exp_done.size() != 0 || grant != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("round_timeout", 0, 1);
    @(negedge clk);
    chk("tx_q_empty", exp_tx.size(), 0);
  endtask
  task automatic run_round(bit ha, bit hb, int g);
    bit first;
    if (ha && hb) begin
      first = !model_last_b;
      push_msg(first);
      push_msg(!first);
      model_last_b = !first;
    end else begin
      push_msg(hb);
      model_last_b = hb;
    end
    fork
      begin if (ha) send(0, g); end
      begin if (hb) send(1, g); end
    join
    wait_end();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit ok;
    int t;
    int unsigned k;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_done", {b_done, a_done}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_grant", grant, 0);
    ma = '{8'hC1}; mb = '{8'hC2};
    run_round(1, 1, 0);
    ma = '{8'h01, 8'h02, 8'h03}; mb = '{8'hB0};
    run_round(1, 1, 0);
    ma = '{8'h5A};
    run_round(1, 0, 0);
    bdelay = 25;
    ma = '{8'h33};
    run_round(1, 0, 0);
    bdelay = 3;
    ma = '{8'h11, 8'h22};
    run_round(1, 0, 10);
    repeat (40) begin
      k = $urandom_range(1, 3);
      ma.delete();
      mb.delete();
      repeat ($urandom_range(1, 4)) ma.push_back(8'($urandom));
      repeat ($urandom_range(1, 4)) mb.push_back(8'($urandom));
      bdelay = $urandom_range(0, 30);
      blen = $urandom_range(1, 25);
      run_round(k[0], k[1], $urandom_range(0, 3));
    end
    bdelay = 25;
    blen = 5;
    exp_tx.push_back(8'hE7);
    set_req(0, 1, 8'hE7, 1);
    wait_rdy(0, ok);
    @(negedge clk);
    set_req(0, 0, 0, 0);
    t = 0;
    while (!tx_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_start", tx_start, 1);
    repeat (5) @(negedge clk);
    set_req(1, 1, 8'h4C, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_tx_start", tx_start, 0);
    chk("arst_grant", grant, 0);
    chk("arst_a_ready", a_ready, 0);
    chk("arst_b_ready", b_ready, 0);
    chk("arst_done", {b_done, a_done}, 0);
    chk("arst_tx_data", tx_data, 0);
    exp_tx.push_back(8'h4C);
    exp_done.push_back(1);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rel_grant", grant, 2'b10);
    chk("rel_b_ready", b_ready, 1);
    @(negedge clk);
    set_req(1, 0, 0, 0);
    wait_end();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter ACK_HOLD, default 16: the minimum number of cycles tx_start is held so the slower UART sampling domain cannot miss it.
REQ-002 The block SHALL have parameter DATA_W, default 8: the byte width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset; all other inputs are synchronous to clk.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a byte
- a_data  in  DATA_W  requester A byte
- a_last  in  1  final byte of A's message
- a_ready  out  1  A's byte is accepted when a_valid & a_ready
- a_done  out  1  one-cycle pulse: A's message is fully transmitted
- b_valid, b_data, b_last, b_ready, b_done  same as the A ports, for requester B
- tx_data  out  DATA_W  byte to the UART transmitter
- tx_start  out  1  transmit request, stretched
- tx_busy  in  1  transmitter busy, already synchronized into clk domain
- grant  out  2  one-hot owner of the transmitter ({B,A}); 00 = none

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, START and WAIT_DONE.
REQ-005 In IDLE with a_valid or b_valid high, the block SHALL set grant and go to FETCH on the next edge.
- If both are valid, the requester not served last wins (round-robin).
- After reset, A has priority.
REQ-006 Grant SHALL stay locked to one requester from FETCH until its last byte completes; the other requester is ignored meanwhile.
REQ-007 In FETCH, ready SHALL be 1 for the granted requester only.
- On valid & ready, data and last are captured into internal registers and the FSM goes to START.
- If valid is low, the FSM waits in FETCH with ready held high.
REQ-008 In START, tx_start SHALL be 1 and tx_data SHALL equal the captured byte.
- A hold counter counts the cycles spent in START.
- START exits to WAIT_DONE only when the counter has reached ACK_HOLD-1 and tx_busy is sampled 1 in the same cycle.
- tx_start therefore lasts max(ACK_HOLD, cycles-to-busy) cycles.
REQ-009 tx_data SHALL be stable from entry to START until exit from WAIT_DONE.
REQ-010 In WAIT_DONE, tx_start SHALL be 0, and the FSM waits for tx_busy to be sampled 0.
- If captured last = 0, the FSM goes to FETCH (same grant).
- If captured last = 1, the FSM pulses the granted requester's done for exactly 1 cycle, records it as last served, clears grant and goes to IDLE.
REQ-011 A requester SHALL NOT receive ready outside FETCH, and never while the other requester holds grant.
REQ-012 Each done pulse SHALL occur in the same cycle that grant returns to 00.
- A new grant cannot be issued until the next cycle, so there is at least one IDLE cycle between messages.
REQ-013 The hold counter SHALL be wide enough for ACK_HOLD, SHALL saturate at ACK_HOLD-1, and SHALL reset to 0 on every entry to START.
REQ-014 A 1-byte message (valid and last together) SHALL follow the full FETCH -> START -> WAIT_DONE -> IDLE path.
REQ-015 If tx_busy never rises, the block SHALL remain in START with tx_start high indefinitely, with no timeout.

Reset
REQ-016 While rst_n = 0, the block SHALL immediately and asynchronously set state = IDLE, grant = 00, tx_start = 0, tx_data = 0, a_ready = b_ready = 0, a_done = b_done = 0, hold counter = 0, last served = B (so A wins first).
REQ-017 Reset mid-message SHALL abandon the message with no done pulse; after rst_n rises, the block SHALL re-arbitrate from IDLE on the first edge.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- Single byte: A sends 0x5A with last; tx_busy model rises 3 cycles after tx_start and stays high 20 cycles -> tx_start high exactly 16 cycles, tx_data = 0x5A throughout, a_done pulses once after busy falls, grant 01 -> 00.
- Slow busy: tx_busy rises 25 cycles after tx_start -> tx_start stays high 26 cycles, dropping the cycle after busy is sampled.
- Contention: A and B valid in the same IDLE cycle after reset -> A is served first; B waits with b_ready = 0; B is then granted after A's done; a later tie goes to A again (alternation).
- Multi-byte lock: A sends 0x01, 0x02, 0x03 (last on 0x03) while B is valid throughout -> three tx_start episodes in order, b_ready = 0 until a_done, then B is served.
- Stall: the granted requester drops valid between bytes for 10 cycles -> FSM waits in FETCH, ready stays high, no tx_start, and the byte is sent after valid returns.
- Reset: rst_n pulled low during START -> tx_start, grant and ready go to 0 asynchronously with no done pulse; after release, a pending B request is granted on the first edge.
